// File: rtl/hv_bundler_pkg.sv
// hv_bundler_pkg: shared state type and helpers for the saturating bundler
package hv_bundler_pkg;
  typedef enum logic {ACCUM, OUT} state_e;
  function automatic int sat_max(input int cw);
    return (1 << (cw - 1)) - 1;
  endfunction
  function automatic logic binarize(input int c, input logic tie);
    return c > 0 ? 1'b1 : c < 0 ? 1'b0 : tie;
  endfunction
endpackage

// File: rtl/bundler_unit_sat.sv
// bundler_unit_sat: one dimension's multi-input saturating vote counter
module bundler_unit_sat import hv_bundler_pkg::*; #(
  parameter int CounterWidth = 8,
  parameter int NumInputs = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clr_i,
  input  logic                           acc_i,
  input  logic [NumInputs-1:0]           bits_i,
  input  logic [NumInputs-1:0]           en_i,
  output logic signed [CounterWidth-1:0] cnt_o,
  output logic signed [CounterWidth-1:0] cnt_d_o,
  output logic                           sat_o
);
  localparam logic signed [CounterWidth:0] Hi = (CounterWidth + 1)'(sat_max(CounterWidth));
  localparam logic signed [CounterWidth:0] Lo = -Hi;
  localparam logic signed [CounterWidth:0] One = 1;
  logic signed [CounterWidth-1:0] cnt_q, cnt_d;
  logic signed [CounterWidth:0] sum;
  logic over, under;
  always_comb begin
    sum = {cnt_q[CounterWidth-1], cnt_q};
    for (int k = 0; k < NumInputs; k++)
      sum = en_i[k] ? (bits_i[k] ? sum + One : sum - One) : sum;
    over = sum > Hi;
    under = sum < Lo;
    cnt_d = clr_i ? '0 : !acc_i ? cnt_q : over ? Hi[CounterWidth-1:0] :
            under ? Lo[CounterWidth-1:0] : sum[CounterWidth-1:0];
    sat_o = acc_i && !clr_i && (over || under);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt_o = cnt_q;
  assign cnt_d_o = cnt_d;
endmodule

// File: rtl/bundler_set_sat.sv
// bundler_set_sat: multi-input saturating hypervector bundler with binarized output handshake
module bundler_set_sat import hv_bundler_pkg::*; #(
  parameter int HVDimension = 512,
  parameter int CounterWidth = 8,
  parameter int NumInputs = 2,
  parameter int SampleWidth = 16
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [NumInputs-1:0][HVDimension-1:0]     hv_i,
  input  logic [NumInputs-1:0]                      hv_en_i,
  input  logic                                      hv_valid_i,
  output logic                                      hv_ready_o,
  input  logic [HVDimension-1:0]                    tie_hv_i,
  input  logic                                      clr_i,
  input  logic                                      binarize_i,
  input  logic                                      auto_clr_i,
  output logic [HVDimension-1:0]                    hv_o,
  output logic                                      hv_valid_o,
  input  logic                                      hv_ready_i,
  output logic [HVDimension-1:0][CounterWidth-1:0]  counter_o,
  output logic [SampleWidth-1:0]                    sample_count_o,
  output logic                                      sat_o
);
  state_e state_q, state_d;
  logic acc, bin, hs, unit_clr, sat_q, sat_d;
  logic [HVDimension-1:0] hv_q, hv_d, hv_bin, sat_hit;
  logic [SampleWidth-1:0] sc_q, sc_d;
  logic [SampleWidth:0] sc_sum;
  for (genvar d = 0; d < HVDimension; d++) begin : g_dim
    logic [NumInputs-1:0] bits;
    logic signed [CounterWidth-1:0] nxt;
    for (genvar k = 0; k < NumInputs; k++) begin : g_bit
      assign bits[k] = hv_i[k][d];
    end
    bundler_unit_sat #(.CounterWidth(CounterWidth), .NumInputs(NumInputs)) u_unit (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .clr_i(unit_clr),
      .acc_i(acc),
      .bits_i(bits),
      .en_i(hv_en_i),
      .cnt_o(counter_o[d]),
      .cnt_d_o(nxt),
      .sat_o(sat_hit[d])
    );
    assign hv_bin[d] = binarize(int'(nxt), tie_hv_i[d]);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ACCUM;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = clr_i ? ACCUM : (state_q == ACCUM) ? (binarize_i ? OUT : ACCUM) :
              (hv_ready_i ? ACCUM : OUT);
  end
  always_comb begin
    hv_ready_o = (state_q == ACCUM) && !clr_i;
    hv_valid_o = state_q == OUT;
    acc = hv_valid_i && hv_ready_o;
    bin = (state_q == ACCUM) && binarize_i && !clr_i;
    hs = hv_valid_o && hv_ready_i;
    unit_clr = clr_i || (hs && auto_clr_i);
  end
  always_comb begin
    hv_d = bin ? hv_bin : hv_q;
    sc_sum = {1'b0, sc_q} + (SampleWidth + 1)'($countones(hv_en_i));
    sc_d = unit_clr ? '0 : !acc ? sc_q : sc_sum[SampleWidth] ? '1 : sc_sum[SampleWidth-1:0];
    sat_d = unit_clr ? 1'b0 : sat_q || (|sat_hit);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hv_q <= '0;
      sc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      hv_q <= hv_d;
      sc_q <= sc_d;
      sat_q <= sat_d;
    end
  end
  assign hv_o = hv_q;
  assign sample_count_o = sc_q;
  assign sat_o = sat_q;
endmodule

// File: tb/tb_bundler_set_sat.sv
// tb_bundler_set_sat: directed and randomized checks against a behavioural bundle model
module tb_bundler_set_sat;
  localparam int HV = 512;
  localparam int CW = 8;
  localparam int NI = 2;
  localparam int SW = 16;
  localparam int MAX = 127;
  localparam int SMAX = 65535;
  logic clk = 1'b0;
  logic rst_i, hv_valid_i, hv_ready_o, clr_i, binarize_i, auto_clr_i, hv_valid_o, hv_ready_i, sat_o;
  logic [NI-1:0][HV-1:0] hv_i;
  logic [NI-1:0] hv_en_i;
  logic [HV-1:0] tie_hv_i, hv_o;
  logic [HV-1:0][CW-1:0] counter_o;
  logic [SW-1:0] sample_count_o;
  int checks = 0;
  int errors = 0;
  int m_cnt[HV];
  logic [HV-1:0] m_hv;
  int m_samples;
  bit m_sat, m_out;
  bundler_set_sat #(.HVDimension(HV), .CounterWidth(CW), .NumInputs(NI), .SampleWidth(SW)) dut (
    .clk_i(clk), .rst_i(rst_i), .hv_i(hv_i), .hv_en_i(hv_en_i), .hv_valid_i(hv_valid_i),
    .hv_ready_o(hv_ready_o), .tie_hv_i(tie_hv_i), .clr_i(clr_i), .binarize_i(binarize_i),
    .auto_clr_i(auto_clr_i), .hv_o(hv_o), .hv_valid_o(hv_valid_o), .hv_ready_i(hv_ready_i),
    .counter_o(counter_o), .sample_count_o(sample_count_o), .sat_o(sat_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [HV-1:0] obs, input logic [HV-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clear_bundle();
    for (int d = 0; d < HV; d++) m_cnt[d] = 0;
    m_samples = 0;
    m_sat = 0;
  endtask
  task automatic model_edge();
    if (rst_i) begin
      clear_bundle();
      m_hv = '0;
      m_out = 0;
    end else if (clr_i) begin
      clear_bundle();
      m_out = 0;
    end else if (m_out) begin
      if (hv_ready_i) begin
        m_out = 0;
        if (auto_clr_i) clear_bundle();
      end
    end else begin
      if (hv_valid_i) begin
        for (int d = 0; d < HV; d++) begin
          int s;
          s = m_cnt[d];
          for (int k = 0; k < NI; k++) if (hv_en_i[k]) s += hv_i[k][d] ? 1 : -1;
          if (s > MAX) begin s = MAX; m_sat = 1; end
          else if (s < -MAX) begin s = -MAX; m_sat = 1; end
          m_cnt[d] = s;
        end
        for (int k = 0; k < NI; k++) if (hv_en_i[k]) m_samples++;
        if (m_samples > SMAX) m_samples = SMAX;
      end
      if (binarize_i) begin
        for (int d = 0; d < HV; d++) m_hv[d] = m_cnt[d] > 0 ? 1'b1 : m_cnt[d] < 0 ? 1'b0 : tie_hv_i[d];
        m_out = 1;
      end
    end
  endtask
  task automatic check_all();
    logic [HV-1:0][CW-1:0] e;
    for (int d = 0; d < HV; d++) e[d] = CW'(m_cnt[d]);
    checks++;
    assert (counter_o === e) else begin : cnt_fail
      int f;
      f = 0;
      errors++;
      for (int d = HV - 1; d >= 0; d--) if (counter_o[d] !== e[d]) f = d;
      $error("FAIL counter dim %0d: observed %0d expected %0d", f, $signed(counter_o[f]), m_cnt[f]);
    end
    chk("hv_o", hv_o, m_hv);
    chk("hv_valid", HV'(hv_valid_o), HV'(m_out));
    chk("samples", HV'(sample_count_o), HV'(m_samples));
    chk("sat", HV'(sat_o), HV'(m_sat));
  endtask
  task automatic cycle();
    #2;
    if (!rst_i) chk("ready", HV'(hv_ready_o), HV'(!m_out && !clr_i));
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic idle();
    hv_valid_i = 0; binarize_i = 0; clr_i = 0; auto_clr_i = 0; hv_ready_i = 0;
    hv_en_i = '1; hv_i = '0;
  endtask
  task automatic rand_vec(output logic [HV-1:0] v);
    for (int w = 0; w < HV / 32; w++) v[w*32 +: 32] = $urandom;
  endtask
  initial begin
    logic [HV-1:0] t;
    m_hv = '0; m_out = 0;
    clear_bundle();
    tie_hv_i = '0;
    rst_i = 1;
    idle();
    cycle();
    cycle();
    rst_i = 0;
    #1;
    chk("reset_ready", HV'(hv_ready_o), HV'(1'b1));
    hv_i[0] = '1; hv_i[1] = '0; hv_en_i = 2'b11; hv_valid_i = 1;
    cycle();
    chk("s1_cnt0", HV'(counter_o[0]), HV'(8'd0));
    hv_valid_i = 0; binarize_i = 1; tie_hv_i = {(HV / 8){8'hA5}};
    cycle();
    chk("s1_hv_tie", hv_o, {(HV / 8){8'hA5}});
    chk("s1_samples", HV'(sample_count_o), HV'(2));
    idle(); hv_ready_i = 1; auto_clr_i = 1;
    cycle();
    idle(); hv_en_i = 2'b01; hv_i[0] = '1; hv_valid_i = 1;
    for (int i = 0; i < 130; i++) cycle();
    chk("s2_cnt_top", HV'(counter_o[HV-1]), HV'(8'd127));
    chk("s2_sat", HV'(sat_o), HV'(1'b1));
    hv_i[0] = '0;
    cycle();
    chk("s2_cnt_126", HV'(counter_o[0]), HV'(8'd126));
    chk("s2_sat_sticky", HV'(sat_o), HV'(1'b1));
    idle(); binarize_i = 1;
    cycle();
    idle(); hv_valid_i = 1; hv_i = '1;
    for (int i = 0; i < 5; i++) cycle();
    chk("s4_hold_cnt", HV'(counter_o[3]), HV'(8'd126));
    chk("s4_hold_valid", HV'(hv_valid_o), HV'(1'b1));
    chk("s4_hold_ready", HV'(hv_ready_o), HV'(1'b0));
    idle(); hv_ready_i = 1; auto_clr_i = 1;
    cycle();
    idle();
    #1;
    chk("s4_cleared", HV'(counter_o[0]), HV'(8'd0));
    chk("s4_ready", HV'(hv_ready_o), HV'(1'b1));
    hv_en_i = 2'b01; hv_valid_i = 1; hv_i[0] = '0; hv_i[0][0] = 1'b1;
    cycle();
    cycle();
    hv_i[0][0] = 1'b0; binarize_i = 1;
    cycle();
    chk("s3_cnt0", HV'(counter_o[0]), HV'(8'd1));
    chk("s3_hv0", HV'(hv_o[0]), HV'(1'b1));
    chk("s3_valid", HV'(hv_valid_o), HV'(1'b1));
    idle(); hv_ready_i = 1;
    cycle();
    idle(); clr_i = 1; hv_valid_i = 1; binarize_i = 1; hv_i = '1;
    #1;
    chk("s5_clr_ready", HV'(hv_ready_o), HV'(1'b0));
    cycle();
    chk("s5_clr_cnt", HV'(counter_o[0]), HV'(8'd0));
    chk("s5_clr_valid", HV'(hv_valid_o), HV'(1'b0));
    idle(); hv_valid_i = 1; binarize_i = 1; hv_i = '1;
    cycle();
    idle(); clr_i = 1;
    cycle();
    chk("s5_abort", HV'(hv_valid_o), HV'(1'b0));
    idle(); hv_en_i = 2'b11; hv_i = '1; hv_valid_i = 1;
    for (int i = 0; i < 70; i++) cycle();
    idle(); binarize_i = 1;
    cycle();
    idle(); rst_i = 1;
    cycle();
    rst_i = 0;
    #1;
    chk("s6_rst_cnt", HV'(counter_o[7]), HV'(8'd0));
    chk("s6_rst_hv", hv_o, '0);
    chk("s6_rst_sat", HV'(sat_o), HV'(1'b0));
    chk("s6_rst_ready", HV'(hv_ready_o), HV'(1'b1));
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NI; k++) begin
        rand_vec(t);
        hv_i[k] = ($urandom % 3 == 0) ? '1 : t;
      end
      rand_vec(t);
      tie_hv_i = t;
      hv_en_i = NI'($urandom_range(0, 3));
      hv_valid_i = ($urandom % 4) != 0;
      binarize_i = ($urandom % 8) == 0;
      hv_ready_i = ($urandom % 2) == 0;
      auto_clr_i = ($urandom % 2) == 0;
      clr_i = ($urandom % 25) == 0;
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
